cic_decimator: RTL and testbench

//  Multi-stage, runtime-rate CIC decimator with a single clock and a qualified input strobe.

---
 rtl/cic_pkg.sv | 30 +++
 rtl/cic_decimator_if.sv | 13 +
 rtl/cic_comb_stage.sv | 49 ++++
 rtl/cic_decimator.sv | 175 +++++++++++++++++
 tb/tb_cic_decimator.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cic_pkg.sv
// Shared CIC helpers: datapath width derivation, rate field sizing and ratio clamping.
// Also used by the interpolator, so nothing here is specific to decimation.
package cic_pkg;

   localparam int unsigned CIC_R_MAX_DFLT = 32'd32;

   function automatic int unsigned cic_acc_w(input int unsigned in_w, input int unsigned order,
                                             input int unsigned r_max, input int unsigned m);
      return in_w + order * $clog2(r_max * m);
   endfunction

   function automatic int unsigned cic_rate_w(input int unsigned r_max);
      return $clog2(r_max) + 32'd1;
   endfunction

   typedef logic [cic_rate_w(CIC_R_MAX_DFLT)-1:0] cic_rate_t;

   function automatic int unsigned clamp_rate(input int unsigned rate, input int unsigned r_max);
      int unsigned r;
      if (rate == 32'd0) begin
         r = 32'd1;
      end else if (rate > r_max) begin
         r = r_max;
      end else begin
         r = rate;
      end
      return r;
   endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream into and out of the CIC decimator; slave is the decimator side.
interface cic_decimator_if #(
   parameter int IN_W  = 25,
   parameter int OUT_W = 25
);
   logic                    data_i_en;
   logic signed [IN_W-1:0]  data_i;
   logic                    data_o_en;
   logic signed [OUT_W-1:0] data_o;

   modport master (output data_i_en, output data_i, input data_o_en, input data_o);
   modport slave  (input data_i_en, input data_i, output data_o_en, output data_o);
endinterface

// File: rtl/cic_comb_stage.sv
// One CIC comb: y = x - x delayed by M tokens. The delay line only moves on a valid token.
module cic_comb_stage #(
   parameter int W = 40,
   parameter int M = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vld_i,
   input  logic signed [W-1:0] x_i,
   output logic                vld_o,
   output logic signed [W-1:0] y_o
);
   logic signed [W-1:0] dly_q [M];
   logic signed [W-1:0] dly_d [M];
   logic signed [W-1:0] y_q;
   logic signed [W-1:0] y_d;
   logic                vld_q;

   always_comb begin
      dly_d = dly_q;
      y_d   = y_q;
      if (vld_i) begin
         y_d      = x_i - dly_q[M-1];
         dly_d[0] = x_i;
         for (int i = 1; i < M; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end else begin
         y_d = y_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < M; i++) begin
            dly_q[i] <= {W{1'b0}};
         end
         y_q   <= {W{1'b0}};
         vld_q <= 1'b0;
      end else begin
         dly_q <= dly_d;
         y_q   <= y_d;
         vld_q <= vld_i;
      end
   end

   assign vld_o = vld_q;
   assign y_o   = y_q;
endmodule

// File: rtl/cic_decimator.sv
// Runtime-rate CIC decimator: token-qualified integrators, period counter, combs, scaler.
// Define CIC_DEC_ROUND_EN to round half up and saturate in the scaler; default truncates.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int IN_W  = 25,
   parameter int OUT_W = 25,
   parameter int ORDER = 3,
   parameter int R_MAX = 32,
   parameter int M     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [cic_rate_w(R_MAX)-1:0] rate_i,
   cic_decimator_if.slave               strm_if,
   output logic [cic_rate_w(R_MAX)-1:0] rate_o
);
   localparam int ACC_W  = int'(cic_acc_w(IN_W, ORDER, R_MAX, M));
   localparam int RATE_W = int'(cic_rate_w(R_MAX));
   localparam int SHIFT  = ACC_W - OUT_W;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [RATE_W-1:0]       rate_t;

   localparam rate_t RATE_ONE = {{(RATE_W-1){1'b0}}, 1'b1};

   acc_t             integ_q [ORDER];
   acc_t             integ_d [ORDER];
   logic [ORDER-1:0] vld_i_q;
   logic [ORDER-1:0] vld_i_d;
   acc_t             x0;

   rate_t cnt_q, cnt_d;
   rate_t rate_q, rate_d;
   rate_t rate_clamped;
   acc_t  dec_q, dec_d;
   logic  dec_vld_q, dec_vld_d;

   acc_t  comb_x [ORDER+1];
   logic  comb_v [ORDER+1];

   logic signed [OUT_W-1:0] scaled;
   logic signed [OUT_W-1:0] data_q, data_d;
   logic                    data_en_q;

   assign x0           = {{(ACC_W-IN_W){strm_if.data_i[IN_W-1]}}, strm_if.data_i};
   assign rate_clamped = rate_t'(clamp_rate(32'(rate_i), 32'(R_MAX)));

   // Each integrator adds its upstream value in the cycle that value's token arrives.
   always_comb begin
      integ_d    = integ_q;
      vld_i_d    = {ORDER{1'b0}};
      vld_i_d[0] = strm_if.data_i_en;
      if (strm_if.data_i_en) begin
         integ_d[0] = integ_q[0] + x0;
      end else begin
         integ_d[0] = integ_q[0];
      end
      for (int k = 1; k < ORDER; k++) begin
         vld_i_d[k] = vld_i_q[k-1];
         if (vld_i_q[k-1]) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
         end else begin
            integ_d[k] = integ_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < ORDER; k++) begin
            integ_q[k] <= {ACC_W{1'b0}};
         end
         vld_i_q <= {ORDER{1'b0}};
      end else begin
         integ_q <= integ_d;
         vld_i_q <= vld_i_d;
      end
   end

   // A new ratio is only adopted when a period closes, so no partial period is ever emitted.
   always_comb begin
      cnt_d     = cnt_q;
      rate_d    = rate_q;
      dec_d     = dec_q;
      dec_vld_d = 1'b0;
      if (vld_i_q[ORDER-1]) begin
         if (cnt_q == rate_q - RATE_ONE) begin
            cnt_d     = {RATE_W{1'b0}};
            dec_d     = integ_q[ORDER-1];
            dec_vld_d = 1'b1;
            rate_d    = rate_clamped;
         end else begin
            cnt_d = cnt_q + RATE_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= {RATE_W{1'b0}};
         rate_q    <= rate_clamped;
         dec_q     <= {ACC_W{1'b0}};
         dec_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         rate_q    <= rate_d;
         dec_q     <= dec_d;
         dec_vld_q <= dec_vld_d;
      end
   end

   assign comb_x[0] = dec_q;
   assign comb_v[0] = dec_vld_q;

   for (genvar k = 0; k < ORDER; k++) begin : g_comb
      cic_comb_stage #(
         .W (ACC_W),
         .M (M)
      ) u_comb (
         .clk   (clk),
         .rst   (rst),
         .vld_i (comb_v[k]),
         .x_i   (comb_x[k]),
         .vld_o (comb_v[k+1]),
         .y_o   (comb_x[k+1])
      );
   end

`ifdef CIC_DEC_ROUND_EN
   localparam logic signed [ACC_W:0] RND_HALF = {{(OUT_W+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

   logic signed [ACC_W:0] rnd_sum;
   logic signed [OUT_W:0] rnd_top;

   assign rnd_sum = {comb_x[ORDER][ACC_W-1], comb_x[ORDER]} + RND_HALF;
   assign rnd_top = (OUT_W+1)'(rnd_sum >>> SHIFT);

   // Adding the half-LSB can only push upward, so positive overflow is the only case to catch.
   always_comb begin
      if (!rnd_top[OUT_W] && rnd_top[OUT_W-1]) begin
         scaled = OUT_MAX;
      end else begin
         scaled = rnd_top[OUT_W-1:0];
      end
   end
`else
   assign scaled = OUT_W'(comb_x[ORDER] >>> SHIFT);
`endif

   always_comb begin
      if (comb_v[ORDER]) begin
         data_d = scaled;
      end else begin
         data_d = data_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= {OUT_W{1'b0}};
         data_en_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         data_en_q <= comb_v[ORDER];
      end
   end

   assign strm_if.data_o    = data_q;
   assign strm_if.data_o_en = data_en_q;
   assign rate_o            = rate_q;
endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: a sample-level CIC model feeds a scoreboard of
// expected (value, cycle) pairs that every output pulse is checked against.
module tb_cic_decimator;
   localparam int IN_W  = 25;
   localparam int OUT_W = 25;
   localparam int ORDER = 3;
   localparam int R_MAX = 32;
   localparam int M     = 1;
   localparam int LAT   = 2 * ORDER + 2;

   typedef struct {
      logic signed [OUT_W-1:0] val;
      longint                  due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] rate_i;
   logic [5:0] rate_o;
   longint     cyc = 0;
   int         n_checks = 0;
   int         n_err = 0;
   int         n_pulse = 0;
   int         p0;

   logic signed [39:0] mi [3];
   logic signed [39:0] md [3];
   int                 mcnt;
   int                 mrate;
   exp_t               sbq [$];

   cic_decimator_if #(.IN_W(IN_W), .OUT_W(OUT_W)) dif ();

   cic_decimator #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .ORDER (ORDER),
      .R_MAX (R_MAX),
      .M     (M)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .rate_i  (rate_i),
      .strm_if (dif),
      .rate_o  (rate_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int clampm(input logic [5:0] r);
      if (r == 6'd0) return 1;
      if (r > 6'd32) return 32;
      return int'(r);
   endfunction

   function automatic logic signed [OUT_W-1:0] scale_m(input logic signed [39:0] y);
      longint v;
      v = longint'(y);
`ifdef CIC_DEC_ROUND_EN
      v = (v + 64'sd16384) >>> 15;
      if (v > 64'sd16777215) v = 64'sd16777215;
`else
      v = v >>> 15;
`endif
      return v[OUT_W-1:0];
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mi[k] = 40'sd0;
         md[k] = 40'sd0;
      end
      mcnt  = 0;
      mrate = clampm(rate_i);
      sbq.delete();
   endtask

   task automatic model_accept(input logic signed [IN_W-1:0] x, input longint due);
      logic signed [39:0] v;
      logic signed [39:0] t;
      exp_t e;
      mi[0] = mi[0] + x;
      mi[1] = mi[1] + mi[0];
      mi[2] = mi[2] + mi[1];
      if (mcnt == mrate - 1) begin
         mcnt  = 0;
         mrate = clampm(rate_i);
         v = mi[2];
         for (int k = 0; k < 3; k++) begin
            t     = v - md[k];
            md[k] = v;
            v     = t;
         end
         e.val = scale_m(v);
         e.due = due;
         sbq.push_back(e);
      end else begin
         mcnt++;
      end
   endtask

   task automatic step(input logic en, input logic signed [IN_W-1:0] x);
      @(negedge clk);
      dif.data_i_en = en;
      dif.data_i    = x;
      if (en && !rst) model_accept(x, cyc + LAT);
   endtask

   task automatic feed(input int n, input logic signed [IN_W-1:0] x);
      for (int i = 0; i < n; i++) step(1'b1, x);
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d, want %0d", tag, $signed(act), $signed(exp));
      end
   endtask

   task automatic do_reset(input logic [5:0] r);
      @(negedge clk);
      rst           = 1'b1;
      rate_i        = r;
      dif.data_i_en = 1'b1;
      dif.data_i    = 25'sd777;
      @(negedge clk);
      rst           = 1'b0;
      dif.data_i_en = 1'b0;
      model_reset();
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sbq.size() > 0 && k < 40) begin
         step(1'b0, 25'sd0);
         k++;
      end
      step(1'b0, 25'sd0);
      n_checks++;
      assert (sbq.size() == 0) else begin
         n_err++;
         $error("FAIL drain: %0d expected pulses never arrived, want 0", sbq.size());
      end
   endtask

   // Scoreboard consumer: each pulse must match the oldest expectation in value and cycle.
   always @(negedge clk) begin
      exp_t e;
      if (dif.data_o_en === 1'b1) begin
         n_pulse++;
         n_checks++;
         assert (sbq.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_pulse: cyc %0d data_o %0d, want no pulse", cyc, dif.data_o);
         end
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_checks++;
            assert (cyc === e.due) else begin
               n_err++;
               $error("FAIL pulse_cycle: got cyc %0d, want %0d", cyc, e.due);
            end
            n_checks++;
            assert (dif.data_o === e.val) else begin
               n_err++;
               $error("FAIL pulse_data: got %0d, want %0d", dif.data_o, e.val);
            end
         end
      end else if (sbq.size() > 0) begin
         n_checks++;
         assert (sbq[0].due > cyc) else begin
            n_err++;
            $error("FAIL pulse_missing: no pulse at cyc %0d, want data %0d", cyc, sbq[0].val);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      rst           = 1'b1;
      rate_i        = 6'd32;
      dif.data_i_en = 1'b0;
      dif.data_i    = 25'sd0;
      model_reset();

      // 1: R=32, DC 1000
      do_reset(6'd32);
      chk("rst_rate_o", 32'(rate_o), 32'd32);
      chk("rst_data_o", 32'(dif.data_o), 32'd0);
      chk("rst_data_o_en", 32'(dif.data_o_en), 32'd0);
      p0 = n_pulse;
      feed(160, 25'sd1000);
      drain();
      chk("r32_pulse_count", 32'(n_pulse - p0), 32'd5);
      chk("r32_settled", 32'(dif.data_o), 32'd1000);

      // 3 + 2: switch to R=8 mid-period, then settle at R=8
      feed(10, 25'sd1000);
      rate_i = 6'd8;
      chk("rate_hold_mid_period", 32'(rate_o), 32'd32);
      feed(22, 25'sd1000);
      feed(48, 25'sd1000);
      chk("rate_switched", 32'(rate_o), 32'd8);
`ifdef CIC_DEC_ROUND_EN
      chk("r8_settled", 32'(dif.data_o), 32'd16);
`else
      chk("r8_settled", 32'(dif.data_o), 32'd15);
`endif
      drain();

      // 4: R=4, en toggling, full-scale negative DC through integrator wrap
      do_reset(6'd4);
      for (int i = 0; i < 400; i++) begin
         step(1'b1, -25'sd16777216);
         step(1'b0, 25'sd12345);
      end
      chk("r4_wrap_settled", 32'(dif.data_o), -32'sd32768);
      drain();

      // 5: reset mid-period discards the partial period
      do_reset(6'd32);
      chk("rst2_data_o", 32'(dif.data_o), 32'd0);
      feed(20, 25'sd1000);
      do_reset(6'd32);
      chk("rst3_data_o", 32'(dif.data_o), 32'd0);
      chk("rst3_data_o_en", 32'(dif.data_o_en), 32'd0);
      chk("rst3_rate_o", 32'(rate_o), 32'd32);
      p0 = n_pulse;
      feed(31, 25'sd1000);
      drain();
      chk("no_pulse_before_32", 32'(n_pulse - p0), 32'd0);
      feed(1, 25'sd1000);
      drain();
      chk("pulse_at_32", 32'(n_pulse - p0), 32'd1);

      // 6: clamping at reset, R=1 pass-through and back-to-back
      do_reset(6'd0);
      chk("clamp_zero", 32'(rate_o), 32'd1);
      for (int i = 0; i < 24; i++) step(1'($urandom_range(0, 1)), 25'($urandom));
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 25'($urandom));
         if (i >= LAT) chk("r1_back_to_back", 32'(dif.data_o_en), 32'd1);
      end
      drain();
      do_reset(6'd40);
      chk("clamp_high", 32'(rate_o), 32'd32);
      for (int i = 0; i < 90; i++) step(1'($urandom_range(0, 1)), 25'($urandom));
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
